multicycle_seq: RTL
===================

Name: multicycle_seq

Overview:
- Multi-cycle sequencer for the RV32I single-datapath CPU. It replaces the free-running PC load (Load tied high) with a state machine that issues PC, IR, register-file and data-memory strobes.
- It waits on a shared memory-ready handshake for each access.
- It provides debugger run, halt and single-step control at instruction boundaries.
- It sits in CPU between the instruction register/decoder and the PC register, register file and data memory enables. Its state is exported to the watch chain.

Parameters:
- WAIT_MAX, 15, maximum wait cycles for iMemReady in one access before a timeout trap (1..255).

Ports:
- Clk  input  1  CPU clock; all state changes on the rising edge.
- Reset  input  1  asynchronous, active-high reset.
- iOpcode  input  7  instruction[6:0] from the instruction register; valid from DECODE onward.
- iMemReady  input  1  memory access completes in this cycle (instruction and data share it).
- iRun  input  1  debugger level: 1 = free run, 0 = halt at the next instruction boundary.
- iStep  input  1  debugger pulse: in HALT, execute exactly one instruction.
- oFetch  output  1  instruction read request (the PC addresses instruction memory).
- oIRLoad  output  1  capture iIM_Data into the instruction register.
- oPCLoad  output  1  load nextPC into the PC register.
- oRegWrite  output  1  register-file write enable.
- oMemRd  output  1  data memory read enable (oRD).
- oMemWr  output  1  data memory write enable (oWR).
- oState  output  3  current state encoding, for the watch chain.
- oHalted  output  1  state is HALT.
- oTrap  output  1  state is TRAP.
- oTrapCause  output  2  0 none, 1 illegal opcode, 2 memory timeout.
- oInstrCount  output  32  count of retired instructions.

Behaviour:
- State encoding: HALT=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, TRAP=6; 7 is unused and recovers to HALT.
- Reset (asynchronous):
  - state=HALT, oTrapCause=0, oInstrCount=0, wait counter=0.
  - All strobes are 0, oHalted=1, oTrap=0.
  - Reset asserted mid-instruction aborts it; no strobe may be asserted while Reset=1.
- Strobes are combinational from the state, iOpcode and iMemReady. No strobe is active outside the states listed below.
- Opcode classes:
  - R 0110011, I 0010011, LUI 0110111, AUIPC 0010111 (ALU class).
  - LOAD 0000011, STORE 0100011, BRANCH 1100011.
  - JAL 1101111, JALR 1100111 (jump class).
  - Any other opcode is illegal.
- HALT:
  - iStep=1 or iRun=1 -> FETCH.
  - iStep takes priority; it is consumed by leaving HALT and is ignored in every other state.
- FETCH:
  - oFetch=1.
  - iMemReady=1: oIRLoad=1 in the same cycle -> DECODE.
  - Otherwise the wait counter increments. When the counter reaches WAIT_MAX with ready still 0 -> TRAP, cause 2.
- DECODE:
  - Illegal opcode -> TRAP, cause 1.
  - Otherwise -> EXEC.
- EXEC:
  - LOAD or STORE -> MEM.
  - BRANCH: oPCLoad=1, retire.
  - ALU or jump class -> WB.
- MEM:
  - LOAD asserts oMemRd=1; STORE asserts oMemWr=1. The strobe is held until iMemReady.
  - Ready on a LOAD -> WB.
  - Ready on a STORE: oPCLoad=1, retire.
  - Timeout rule is the same as FETCH.
- WB: oRegWrite=1, oPCLoad=1, retire.
- Retire:
  - oInstrCount increments by 1 in the same edge; it wraps 0xFFFFFFFF -> 0.
  - Next state is FETCH if iRun=1, else HALT.
  - Single-step therefore executes one instruction and returns to HALT.
- Wait counter:
  - Cleared on every transition into FETCH or MEM.
  - Width is $clog2(WAIT_MAX+1).
  - A ready arriving in the same cycle the counter hits WAIT_MAX counts as success.
- TRAP:
  - Sticky until Reset; ignores iRun and iStep.
  - All strobes 0, oTrap=1, oTrapCause held.
- Cycle counts with a zero-wait memory:
  - ALU/jump: 4 cycles (FETCH, DECODE, EXEC, WB).
  - Branch: 3.
  - Store: 4.
  - Load: 5.
  - Each memory wait cycle adds 1.
- oInstrCount, oTrapCause and the state register are plain flops; each strobe is asserted at most once per instruction.

Test Plan:
- Reset, iRun=0, no iStep for 10 cycles -> oHalted=1, oState=0, all strobes 0, oInstrCount=0.
- iRun=1, iMemReady=1, opcode 0010011 (addi) -> oFetch/oIRLoad at cycle 1, oRegWrite and oPCLoad together at cycle 4, oInstrCount=1, back in FETCH.
- Opcode 0000011 with iMemReady low for 3 MEM cycles -> oMemRd high for 4 cycles then WB. The load takes 8 cycles total; oRegWrite is asserted once.
- iRun=0, one iStep pulse with a store (0100011) -> exactly one oMemWr/oPCLoad sequence, then HALT, oInstrCount +1. A second iStep asserted during EXEC is ignored.
- Opcode 0000000 -> TRAP at cycle 3, oTrapCause=1. iRun and iStep then have no effect until Reset, which clears the cause to 0.
- FETCH with iMemReady=0 and WAIT_MAX=15 -> TRAP, cause 2, after the 16th FETCH cycle. A variant with ready on exactly the 16th cycle -> DECODE, no trap.

Source files
------------

// File: rtl/multicycle_seq.sv
// Multi-cycle sequencer for the RV32I single-datapath CPU: issues PC/IR/register/memory
// strobes, waits on the shared memory-ready handshake and supports debugger run/halt/step.
module multicycle_seq #(
    parameter int unsigned WAIT_MAX = 15
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [6:0]  iOpcode,
    input  logic        iMemReady,
    input  logic        iRun,
    input  logic        iStep,
    output logic        oFetch,
    output logic        oIRLoad,
    output logic        oPCLoad,
    output logic        oRegWrite,
    output logic        oMemRd,
    output logic        oMemWr,
    output logic [2:0]  oState,
    output logic        oHalted,
    output logic        oTrap,
    output logic [1:0]  oTrapCause,
    output logic [31:0] oInstrCount
);

    localparam int unsigned WW = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(WAIT_MAX);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [1:0] CAUSE_NONE    = 2'd0;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;

    typedef enum logic [2:0] {
        S_HALT   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6
    } state_e;

    state_e        state_q, state_d;
    logic [1:0]    cause_q, cause_d;
    logic [31:0]   count_q, count_d;
    logic [WW-1:0] wait_q,  wait_d;

    logic is_alu, is_load, is_store, is_branch, is_jump, is_legal;
    logic fetch_s, irload_s, pcload_s, regwrite_s, memrd_s, memwr_s, retire_s;

    always_comb begin
        is_alu    = (iOpcode == OP_R) || (iOpcode == OP_I) ||
                    (iOpcode == OP_LUI) || (iOpcode == OP_AUIPC);
        is_load   = (iOpcode == OP_LOAD);
        is_store  = (iOpcode == OP_STORE);
        is_branch = (iOpcode == OP_BRANCH);
        is_jump   = (iOpcode == OP_JAL) || (iOpcode == OP_JALR);
        is_legal  = is_alu || is_load || is_store || is_branch || is_jump;
    end

    always_comb begin
        state_d    = state_q;
        cause_d    = cause_q;
        count_d    = count_q;
        wait_d     = wait_q;
        fetch_s    = 1'b0;
        irload_s   = 1'b0;
        pcload_s   = 1'b0;
        regwrite_s = 1'b0;
        memrd_s    = 1'b0;
        memwr_s    = 1'b0;
        retire_s   = 1'b0;

        case (state_q)
            S_HALT: begin
                if (iStep || iRun) state_d = S_FETCH;
            end
            S_FETCH: begin
                fetch_s = 1'b1;
                if (iMemReady) begin
                    irload_s = 1'b1;
                    state_d  = S_DECODE;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_TIMEOUT;
                end else begin
                    wait_d = wait_q + WW'(1);
                end
            end
            S_DECODE: begin
                if (is_legal) begin
                    state_d = S_EXEC;
                end else begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_ILLEGAL;
                end
            end
            S_EXEC: begin
                if (is_load || is_store) begin
                    state_d = S_MEM;
                end else if (is_branch) begin
                    pcload_s = 1'b1;
                    retire_s = 1'b1;
                end else if (is_alu || is_jump) begin
                    state_d = S_WB;
                end else begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_ILLEGAL;
                end
            end
            S_MEM: begin
                memrd_s = is_load;
                memwr_s = is_store;
                // An opcode that stopped being a memory op is treated as illegal rather than hanging here.
                if (!(is_load || is_store)) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_ILLEGAL;
                end else if (iMemReady) begin
                    if (is_load) begin
                        state_d = S_WB;
                    end else begin
                        pcload_s = 1'b1;
                        retire_s = 1'b1;
                    end
                end else if (wait_q == WAIT_LAST) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_TIMEOUT;
                end else begin
                    wait_d = wait_q + WW'(1);
                end
            end
            S_WB: begin
                regwrite_s = 1'b1;
                pcload_s   = 1'b1;
                retire_s   = 1'b1;
            end
            S_TRAP: begin
                state_d = S_TRAP;
            end
            default: begin
                state_d = S_HALT;
            end
        endcase

        if (retire_s) begin
            count_d = count_q + 32'd1;
            state_d = iRun ? S_FETCH : S_HALT;
        end

        if ((state_d != state_q) && ((state_d == S_FETCH) || (state_d == S_MEM))) begin
            wait_d = '0;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= S_HALT;
            cause_q <= CAUSE_NONE;
            count_q <= '0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            count_q <= count_d;
            wait_q  <= wait_d;
        end
    end

    // Strobes are also masked by Reset so nothing fires while reset is held.
    always_comb begin
        oFetch      = fetch_s    & ~Reset;
        oIRLoad     = irload_s   & ~Reset;
        oPCLoad     = pcload_s   & ~Reset;
        oRegWrite   = regwrite_s & ~Reset;
        oMemRd      = memrd_s    & ~Reset;
        oMemWr      = memwr_s    & ~Reset;
        oState      = state_q;
        oHalted     = (state_q == S_HALT);
        oTrap       = (state_q == S_TRAP);
        oTrapCause  = cause_q;
        oInstrCount = count_q;
    end

endmodule
